// File: rtl/jk_register_bank.sv
// jk_register_bank
// Multi-bit JK storage element with four operating modes: independent
// per-bit JK, modulo-N up counter, modulo-N down counter and shift-left
// register. All synchronous updates happen on the falling edge of clk.
// clr (highest priority) and cls are asynchronous and active-low; clr forces
// zero and cls loads PRESET_VAL. While either is held low, clock edges have
// no effect. qn is always the bitwise complement of q. tc is decoded
// combinationally from q and mode, so it follows a mode change at once.
module jk_register_bank #(
    parameter int                WIDTH      = 4,
    parameter longint unsigned   MODULUS    = 64'd1 << WIDTH,
    parameter logic [WIDTH-1:0]  PRESET_VAL = '1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cls,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             ser_out
);

    // Operating modes
    localparam logic [1:0] MODE_JK    = 2'd0;
    localparam logic [1:0] MODE_UP    = 2'd1;
    localparam logic [1:0] MODE_DOWN  = 2'd2;
    localparam logic [1:0] MODE_SHIFT = 2'd3;

    // Highest count value (MODULUS-1). MODULUS is carried in 64 bits so the
    // default of 2**WIDTH stays representable at WIDTH = 32.
    localparam longint unsigned TOP_WIDE = MODULUS - 64'd1;
    localparam logic [WIDTH-1:0] TOP     = TOP_WIDE[WIDTH-1:0];

    // TOP widened by one bit so the out-of-range compare never degenerates
    // into a comparison against the all-ones value of q's own width.
    localparam logic [WIDTH:0]   TOP_X   = {1'b0, TOP};

    // Per-mode next-state candidates
    logic [WIDTH-1:0] jk_next;
    logic [WIDTH-1:0] up_next;
    logic [WIDTH-1:0] down_next;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] d;

    // Count-state decodes shared by the counters and tc
    logic at_top;
    logic at_zero;
    logic over_range;

    assign at_top     = (q == TOP);
    assign at_zero    = (q == '0);
    // Values above MODULUS-1 can be reached through preset or JK mode.
    assign over_range = ({1'b0, q} > TOP_X);

    // JK characteristic equation, applied to every bit independently:
    // 00 hold, 01 reset, 10 set, 11 toggle.
    assign jk_next = (j & ~q) | (~k & q);

    // Up counter: wrap to zero at the top or from any out-of-range value
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        up_next = q + WIDTH'(1);
        if (at_top || over_range) begin
            up_next = '0;
        end
    end

    // Down counter: wrap to the top from zero or from any out-of-range value
    always_comb begin
        down_next = q - WIDTH'(1);
        if (at_zero || over_range) begin
            down_next = TOP;
        end
    end

    // Shift left with ser_in entering at bit 0; a 1-bit register just loads it
    generate
        if (WIDTH == 1) begin : g_shift_one
            assign shift_next = ser_in;
        end else begin : g_shift_many
            assign shift_next = {q[WIDTH-2:0], ser_in};
        end
    endgenerate

    // Select the next state for the current mode; en low holds q
    always_comb begin
        d = q;
        if (en) begin
            case (mode)
                MODE_JK:    d = jk_next;
                MODE_UP:    d = up_next;
                MODE_DOWN:  d = down_next;
                MODE_SHIFT: d = shift_next;
                default:    d = q;
            endcase
        end
    end

    // State register: async clear over async preset, falling-edge update
    always_ff @(negedge clk or negedge clr or negedge cls) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values and simulation matches hardware.
        if (!clr) begin
            q <= '0;
        end else if (!cls) begin
            q <= PRESET_VAL;
        end else begin
            q <= d;
        end
    end

    // Terminal count: decoded from q and mode only, en is a don't-care
    always_comb begin
        tc = 1'b0;
        case (mode)
            MODE_UP:   tc = at_top;
            MODE_DOWN: tc = at_zero;
            default:   tc = 1'b0;
        endcase
    end

    assign qn      = ~q;
    assign ser_out = q[WIDTH-1];

endmodule

// File: tb/tb_jk_register_bank.sv
// tb_jk_register_bank
// Directed bench for jk_register_bank with WIDTH=4, MODULUS=10 and the default
// preset of 4'b1111. Inputs change one time unit after a falling edge and
// outputs are sampled there, well away from the active edge.
module tb_jk_register_bank;

    localparam int              W = 4;
    localparam longint unsigned M = 10;

    logic         clk;
    logic         clr;
    logic         cls;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         ser_in;
    logic [W-1:0] q;
    logic [W-1:0] qn;
    logic         tc;
    logic         ser_out;

    int n_checks = 0;
    int n_pass   = 0;

    jk_register_bank #(
        .WIDTH   (W),
        .MODULUS (M)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .cls     (cls),
        .en      (en),
        .mode    (mode),
        .j       (j),
        .k       (k),
        .ser_in  (ser_in),
        .q       (q),
        .qn      (qn),
        .tc      (tc),
        .ser_out (ser_out)
    );

    // Falling edges at 5, 15, 25, ...; rising edges at 10, 20, ...
    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n falling edges, ending one time unit after the last one
    task automatic fall(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Safety net so the run always ends
    initial begin
        #20000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "simulation time limit reached");
    end

    logic [W-1:0] sh_exp [4];
    logic         sh_in  [4];

    initial begin
        clr = 1'b1; cls = 1'b1; en = 1'b0; mode = 2'd0;
        j = '0; k = '0; ser_in = 1'b0;
        sh_in  = '{1'b1, 1'b0, 1'b1, 1'b1};
        sh_exp = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};

        // ---------------- async clear / preset ----------------
        #3 clr = 1'b0;
        #1;
        check("clr_async_q",  q,  4'h0);
        check("clr_async_qn", qn, 4'hf);
        fall(1);
        check("clr_edge_ignored", q, 4'h0);
        clr = 1'b1; cls = 1'b0;
        #1;
        check("cls_async_q",  q,  4'hf);
        check("cls_async_qn", qn, 4'h0);
        clr = 1'b0;
        #1;
        check("both_low_q", q, 4'h0);
        en = 1'b1; mode = 2'd1;
        fall(2);
        check("both_low_edges_ignored", q, 4'h0);
        clr = 1'b1;
        #1;
        check("clr_release_no_effect", q, 4'h0);
        fall(1);
        check("cls_held_at_edge", q, 4'hf);
        fall(1);
        check("cls_edge_ignored", q, 4'hf);
        cls = 1'b1;

        // ---------------- up count, MODULUS = 10 ----------------
        fall(1);
        check("up_from_15", q, 4'h0);
        check("up_tc_at_0", tc, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            fall(1);
            check($sformatf("up_step_%0d", i), q, 32'(i));
        end
        check("up_tc_at_9", tc, 1'b1);
        fall(1);
        check("up_wrap_q",  q,  4'h0);
        check("up_wrap_tc", tc, 1'b0);
        fall(9);
        check("up_back_to_9", q, 4'h9);

        // ---------------- rising edges never update q ----------------
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m); en = 1'b1; j = 4'hf; k = 4'hf; ser_in = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("rise_mode%0d", m), q, 4'h9);
            en = 1'b0;
            fall(1);
            check($sformatf("en0_hold_mode%0d", m), q, 4'h9);
        end

        // ---------------- tc follows mode immediately ----------------
        mode = 2'd1; #1; check("tc_mode1_q9", tc, 1'b1);
        mode = 2'd2; #1; check("tc_mode2_q9", tc, 1'b0);
        mode = 2'd0; #1; check("tc_mode0_q9", tc, 1'b0);
        mode = 2'd3; #1; check("tc_mode3_q9", tc, 1'b0);
        mode = 2'd1; #1; check("tc_mode1_en0", tc, 1'b1);
        fall(1);
        check("en0_hold_q9", q, 4'h9);

        // ---------------- down count ----------------
        clr = 1'b0; #1; clr = 1'b1; #1;
        check("mid_cycle_clr", q, 4'h0);
        mode = 2'd2; en = 1'b1;
        #1;
        check("down_tc_at_0", tc, 1'b1);
        fall(1);
        check("down_wrap_q",  q,  4'h9);
        check("down_wrap_tc", tc, 1'b0);
        cls = 1'b0; #1; cls = 1'b1; #1;
        check("mid_cycle_cls", q, 4'hf);
        fall(1);
        check("down_from_15", q, 4'h9);
        fall(1);
        check("down_step_8", q, 4'h8);
        fall(8);
        check("down_to_0_q",  q,  4'h0);
        check("down_to_0_tc", tc, 1'b1);

        // ---------------- per-bit JK ----------------
        mode = 2'd0; j = 4'b0101; k = 4'b1010;
        fall(1);
        check("jk_load_0101", q, 4'b0101);
        // bit3 toggle 0->1, bit2 set, bit1 reset, bit0 hold
        j = 4'b1100; k = 4'b1010;
        fall(1);
        check("jk_mixed_q",  q,  4'b1101);
        check("jk_mixed_qn", qn, 4'b0010);
        check("jk_tc",       tc, 1'b0);
        en = 1'b0;
        fall(1);
        check("jk_en0_hold", q, 4'b1101);
        en = 1'b1;
        fall(1);
        check("jk_toggle_back", q, 4'b0101);

        // ---------------- shift left ----------------
        clr = 1'b0; #1; clr = 1'b1;
        mode = 2'd3;
        for (int i = 0; i < 4; i++) begin
            ser_in = sh_in[i];
            fall(1);
            check($sformatf("shift_%0d", i), q, sh_exp[i]);
        end
        check("shift_ser_out", ser_out, 1'b1);
        check("shift_tc",      tc,      1'b0);
        clr = 1'b0; #1; clr = 1'b1;
        ser_in = 1'b1;
        fall(2);
        check("shift_pre_clr", q, 4'b0011);
        clr = 1'b0;
        #1;
        check("shift_clr_q",  q,  4'h0);
        check("shift_clr_qn", qn, 4'hf);
        clr = 1'b1;
        fall(1);
        check("shift_resume",       q,       4'b0001);
        check("shift_resume_sout",  ser_out, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
